alu_control_md: RTL

// - Next-generation ALU control: decodes ALUOp/funct into the ALU operation code and the Jr flag.
// - Adds an iterative multiply/divide engine with HI/LO registers and a stall handshake for MULT/MULTU/DIV/DIVU/MFHI/MFLO.
// - Sits in the EX stage beside the ALU; md_stall holds IF/ID/EX while the engine is busy.

---
 rtl/alu_control_md_if.sv | 30 +++
 rtl/alu_control_md.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_md_if.sv
// EX-stage bus between the pipeline and the ALU control / multiply-divide block.
// The pipeline side is the master; the control block is the slave.
interface alu_control_md_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             ex_valid;
    logic [2:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [OP_W-1:0]  operation;
    logic             Jr;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             md_busy;
    logic             md_done;
    logic             md_stall;

    modport master (
        output ex_valid, ALUOp, funct, rs_val, rt_val,
        input  operation, Jr, illegal, hi, lo, md_busy, md_done, md_stall
    );

    modport slave (
        input  ex_valid, ALUOp, funct, rs_val, rt_val,
        output operation, Jr, illegal, hi, lo, md_busy, md_done, md_stall
    );
endinterface

// File: rtl/alu_control_md.sv
// ALU control decode plus an iterative multiply/divide engine with HI/LO and an EX stall.
// Define MIPS_MD_DIV_EN to build the restoring divider (DIV/DIVU); otherwise they decode as illegal.
module alu_control_md #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_control_md_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] OP_NOR = OP_W'(4'b1100);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

`ifdef MIPS_MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   p_q, p_d, mul_step, div_step;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   div_hi, div_lo;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_res;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic               is_div_q, is_div_d;
    logic               done_q, done_d;

    logic             rtype, f_mul, f_div, f_mf, md_start, op_signed, busy;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    assign rtype     = (bus.ALUOp == 3'b010);
    assign f_mul     = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
    assign f_div     = DIV_EN && ((bus.funct == F_DIV) || (bus.funct == F_DIVU));
    assign f_mf      = (bus.funct == F_MFHI) || (bus.funct == F_MFLO);
    assign op_signed = ~bus.funct[0];
    assign busy      = (state_q != S_IDLE);
    assign md_start  = (state_q == S_IDLE) && bus.ex_valid && rtype && (f_mul || f_div);

    // Engine works on magnitudes; signs are re-applied in FIX.
    assign rs_neg = op_signed & bus.rs_val[WIDTH-1];
    assign rt_neg = op_signed & bus.rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

    always_comb begin
        bus.operation = OP_ADD;
        bus.Jr        = 1'b0;
        bus.illegal   = 1'b0;
        case (bus.ALUOp)
            3'b001: bus.operation = OP_SUB;
            3'b100: bus.operation = OP_AND;
            3'b101: bus.operation = OP_OR;
            3'b110: bus.operation = OP_SLT;
            3'b010: begin
                case (bus.funct)
                    F_ADD:   bus.operation = OP_ADD;
                    F_SUB:   bus.operation = OP_SUB;
                    F_AND:   bus.operation = OP_AND;
                    F_OR:    bus.operation = OP_OR;
                    F_NOR:   bus.operation = OP_NOR;
                    F_SLT:   bus.operation = OP_SLT;
                    F_JR:    bus.Jr        = 1'b1;
                    F_MULT, F_MULTU, F_MFHI, F_MFLO: bus.operation = OP_ADD;
                    F_DIV, F_DIVU: bus.illegal = !DIV_EN;
                    default: bus.illegal   = 1'b1;
                endcase
            end
            default: bus.operation = OP_ADD;
        endcase
    end

    // Shift-add: upper half accumulates the multiplicand, multiplier shifts out of the bottom.
    assign mul_sum  = p_q[2*WIDTH:WIDTH] + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_step = {1'b0, mul_sum, p_q[WIDTH-1:1]};
    assign mul_res  = (sa_q ^ sb_q) ? -p_q[2*WIDTH-1:0] : p_q[2*WIDTH-1:0];

`ifdef MIPS_MD_DIV_EN
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH:0]   div_shift, div_rem;
    logic             div_ge;
    logic [WIDTH-1:0] quo, rem;

    always_ff @(posedge clk) begin
        if (!rst_n)
            dvsr_q <= '0;
        else if (md_start)
            dvsr_q <= rt_mag;
    end

    // Restoring step: remainder in the upper half, quotient bits shift in at the bottom.
    assign div_shift = p_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = (div_shift >= {1'b0, dvsr_q});
    assign div_rem   = div_ge ? (div_shift - {1'b0, dvsr_q}) : div_shift;
    assign div_step  = {div_rem, p_q[WIDTH-2:0], div_ge};

    assign quo    = p_q[WIDTH-1:0];
    assign rem    = p_q[2*WIDTH-1:WIDTH];
    assign div_lo = (dvsr_q == '0) ? {WIDTH{1'b1}} : ((sa_q ^ sb_q) ? -quo : quo);
    assign div_hi = (dvsr_q == '0) ? (sa_q ? -a_q : a_q) : (sa_q ? -rem : rem);
`else
    assign div_step = p_q;
    assign div_lo   = lo_q;
    assign div_hi   = hi_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        a_d      = a_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d  = f_div ? S_DIV : S_MUL;
                    is_div_d = f_div;
                    sa_d     = rs_neg;
                    sb_d     = rt_neg;
                    a_d      = rs_mag;
                    cnt_d    = '0;
                    p_d      = {{(WIDTH+1){1'b0}}, (f_div ? rs_mag : rt_mag)};
                end
            end
            S_MUL, S_DIV: begin
                p_d   = (state_q == S_DIV) ? div_step : mul_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = div_hi;
                    lo_d = div_lo;
                end else begin
                    {hi_d, lo_d} = mul_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            a_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            a_q      <= a_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_busy  = busy;
    assign bus.md_done  = done_q;
    assign bus.md_stall = bus.ex_valid && busy && rtype && (f_mul || f_div || f_mf);

endmodule
